i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50: 7-bit bus address this target responds to.
REQ-002 SHALL have parameter CLK_FREQ, default 25_000_000: system clock frequency in Hz (informational; it does not affect logic).
REQ-003 SHALL have port i_sys_clk, input, 1 bit: single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port i_sys_rstn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port i2c_scl, input, 1 bit: bus clock, driven by the controller.
REQ-006 SHALL have port i2c_sda, inout, 1 bit: open-drain data line; this block drives only 0 or Z.
REQ-007 SHALL have port i_tx_data, input, 8 bits: byte to return on a read transfer.
REQ-008 SHALL have port o_tx_load, output, 1 bit: one-cycle pulse when i_tx_data is captured.
REQ-009 SHALL have port o_rx_data, output, 8 bits: last byte written by the controller.
REQ-010 SHALL have port o_valid_out, output, 1 bit: one-cycle pulse when o_rx_data updates.
REQ-011 SHALL have port busy, output, 1 bit: high from an addressed START until STOP or NACK.

Function
REQ-012 SHALL pass i2c_scl and i2c_sda through 2-flop synchronizers; all edge detection uses synchronized, registered values.
REQ-013 SHALL support SCL up to i_sys_clk/16.
REQ-014 SHALL detect START as synchronized SDA 1->0 while SCL is high, and STOP as SDA 0->1 while SCL is high.
REQ-015 SHALL sample SDA on SCL rising edges, change its SDA drive only on SCL falling edges, and register its SDA drive (no glitches).
REQ-016 SHALL implement the states IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK and WAIT_STOP.
REQ-017 SHALL go from any state to ADDR on START, including repeated START, with the bit counter cleared.
REQ-018 SHALL go from any state to IDLE on STOP, releasing SDA and clearing busy.
REQ-019 ADDR SHALL shift 8 bits MSB-first: address[6:0], then R/W.
- On address match: go to ADDR_ACK, drive SDA low for the 9th clock, and set busy.
- On mismatch: go to WAIT_STOP with SDA released.
REQ-020 SHALL leave ADDR_ACK on the falling edge that ends the 9th clock.
- R/W = 0: go to RX_BYTE and release SDA.
- R/W = 1: go to TX_BYTE, capture i_tx_data, pulse o_tx_load, and drive its MSB.
REQ-021 RX_BYTE SHALL shift 8 bits MSB-first.
- After the 8th rising edge: update o_rx_data, pulse o_valid_out once.
- On the next falling edge: drive ACK low (RX_ACK); release it at the end of the 9th clock and return to RX_BYTE.
REQ-022 TX_BYTE SHALL shift the captured byte MSB-first, releasing SDA (Z) for 1-bits, then release SDA for the 9th clock (TX_ACK).
REQ-023 TX_ACK SHALL sample the controller's ACK on the 9th rising edge.
- ACK (0): on the next falling edge, load the next i_tx_data, pulse o_tx_load, return to TX_BYTE.
- NACK (1): go to WAIT_STOP and clear busy.
REQ-024 WAIT_STOP SHALL keep SDA released and ignore data until START or STOP.
REQ-025 If START and STOP are detected in the same cycle (impossible on a legal bus), SHALL give STOP priority.
REQ-026 The general-call address 7'h00 SHALL be treated as a mismatch.

Reset
REQ-027 On i_sys_rstn = 0, SHALL immediately set state = IDLE and release SDA to Z.
REQ-028 On reset, SHALL set o_rx_data = 8'h00, o_valid_out = 0, o_tx_load = 0, busy = 0, clear the bit counter and shift registers, and preset the synchronizers to 1.
REQ-029 Reset asserted mid-transfer SHALL abort without driving SDA; after release the block SHALL wait in IDLE for the next START.

Verification
REQ-030 Write: START, 0xA0, 0x3C, STOP -> ACK low on both 9th clocks; o_rx_data = 8'h3C; exactly one o_valid_out pulse; busy 1 then 0 after STOP.
REQ-031 Read: START, 0xA1, i_tx_data = 8'h96, controller ACK, then i_tx_data = 8'h5A, controller NACK, STOP -> SDA bits 10010110 then 01011010; two o_tx_load pulses; SDA released after the NACK.
REQ-032 Mismatch: START, 0xA2, 0x11, STOP -> SDA never driven low; no o_valid_out pulse; busy stays 0.
REQ-033 Repeated START: START, 0xA0, 0x07, Sr, 0xA1, read one byte, NACK, STOP -> o_rx_data = 8'h07; the address is ACKed twice; the read returns i_tx_data.
REQ-034 Reset mid-byte: assert i_sys_rstn low after 4 bits of 0xA0 -> SDA = Z, all outputs at reset values; a following full write of 0x55 is ACKed and o_rx_data = 8'h55.

Source files
------------

// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit addressed I2C target that receives bytes on writes and returns host-supplied bytes on reads.
// SCL/SDA are oversampled by i_sys_clk; SDA is only ever pulled low or released.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         CLK_FREQ   = 25_000_000
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rstn,
    input  logic       i2c_scl,
    inout  logic       i2c_sda,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_load,
    output logic [7:0] o_rx_data,
    output logic       o_valid_out,
    output logic       busy
);
    if (CLK_FREQ <= 0) begin : g_freq_check
        $error("CLK_FREQ must be positive");
    end

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  scl_sync_q, sda_sync_q;
    logic        scl_prev_q, sda_prev_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        rw_q, rw_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        load_q, load_d;
    logic        scl, sda, scl_rise, scl_fall, start, stop;

    assign scl      = scl_sync_q[1];
    assign sda      = sda_sync_q[1];
    assign scl_rise = scl & ~scl_prev_q;
    assign scl_fall = ~scl & scl_prev_q;
    // Bus conditions need SCL high on both the current and the previous sample.
    assign start    = scl & scl_prev_q & sda_prev_q & ~sda;
    assign stop     = scl & scl_prev_q & ~sda_prev_q & sda;

    always_ff @(posedge i_sys_clk or negedge i_sys_rstn) begin
        if (!i_sys_rstn) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i2c_scl};
            sda_sync_q <= {sda_sync_q[0], i2c_sda};
            scl_prev_q <= scl;
            sda_prev_q <= sda;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            load_q     <= load_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rw_d     = rw_q;
        sda_oe_d = sda_oe_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        load_d   = 1'b0;
        if (stop) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        // General call (all-zero address) is never claimed.
                        if (shift_q[7:1] == SLAVE_ADDR && shift_q[7:1] != 7'h00) begin
                            state_d  = ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shift_q[0];
                        end else begin
                            state_d = WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d    = 4'd0;
                        state_d  = rw_q ? TX_BYTE : RX_BYTE;
                        tx_d     = rw_q ? i_tx_data : tx_q;
                        load_d   = rw_q;
                        sda_oe_d = rw_q & ~i_tx_data[7];
                    end
                end
                RX_BYTE: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rx_d    = {shift_q[6:0], sda};
                            valid_d = 1'b1;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        state_d  = RX_ACK;
                        sda_oe_d = 1'b1;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        state_d  = RX_BYTE;
                        cnt_d    = 4'd0;
                        sda_oe_d = 1'b0;
                    end
                end
                TX_BYTE: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        state_d  = TX_ACK;
                        sda_oe_d = 1'b0;
                    end else if (scl_fall && cnt_q != 4'd0) begin
                        // ~cnt[2:0] == 7-cnt: bit to present after cnt rising edges.
                        sda_oe_d = ~tx_q[~cnt_q[2:0]];
                    end
                end
                TX_ACK: begin
                    if (scl_rise && sda) begin
                        state_d = WAIT_STOP;
                        busy_d  = 1'b0;
                    end else if (scl_fall) begin
                        state_d  = TX_BYTE;
                        cnt_d    = 4'd0;
                        tx_d     = i_tx_data;
                        load_d   = 1'b1;
                        sda_oe_d = ~i_tx_data[7];
                    end
                end
                default: ;
            endcase
        end
    end

    assign i2c_sda     = sda_oe_q ? 1'b0 : 1'bz;
    assign o_tx_load   = load_q;
    assign o_rx_data   = rx_q;
    assign o_valid_out = valid_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C controller driving i2c_slave, checked against a transaction-level model.
module tb_i2c_slave;
    localparam logic [6:0] SLV = 7'h50;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load, valid, busy;
    logic [7:0] rx_data;
    wire        sda_w;

    pullup (sda_w);
    assign sda_w = m_low ? 1'b0 : 1'bz;

    i2c_slave #(.SLAVE_ADDR(SLV), .CLK_FREQ(100_000_000)) dut (
        .i_sys_clk(clk), .i_sys_rstn(rstn), .i2c_scl(scl), .i2c_sda(sda_w),
        .i_tx_data(tx_data), .o_tx_load(tx_load), .o_rx_data(rx_data),
        .o_valid_out(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;
    int n_valid = 0, n_load = 0, n_low = 0;
    logic [7:0] model_rx = 8'h00;
    logic [7:0] dat [5];

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (tx_load) n_load++;
        if (sda_w === 1'b0 && !m_low) n_low++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bitx(input logic b, output logic r);
        m_low = ~b;
        #40 scl = 1'b1;
        #40 r = sda_w;
        #40 scl = 1'b0;
        #40;
    endtask

    task automatic start_c;
        m_low = 1'b0;
        #40 scl = 1'b1;
        #40 m_low = 1'b1;
        #40 scl = 1'b0;
        #40;
    endtask

    task automatic stop_c;
        m_low = 1'b1;
        #40 scl = 1'b1;
        #40 m_low = 1'b0;
        #80;
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bitx(d[i], r);
        bitx(1'b1, r);
        ack = ~r;
    endtask

    task automatic rbyte(input logic nack, input logic [7:0] nxt, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bitx(1'b1, r);
            d[i] = r;
        end
        tx_data = nxt;
        bitx(nack, r);
    endtask

    // Model: only SLV is claimed; claimed writes ACK every byte and leave the last one
    // on o_rx_data; claimed reads return each presented byte; unclaimed traffic sees a floating bus.
    task automatic run_xfer(input logic [6:0] a, input logic rw, input int n);
        logic ack;
        logic [7:0] got;
        int v0, l0, w0;
        logic exp_ack;
        exp_ack = (a == SLV) && (a != 7'h00);
        v0 = n_valid; l0 = n_load; w0 = n_low;
        tx_data = dat[0];
        start_c;
        wbyte({a, rw}, ack);
        check("addr_ack", ack, exp_ack);
        check("busy_addr", busy, exp_ack);
        for (int k = 0; k < n; k++) begin
            if (!rw) begin
                wbyte(dat[k], ack);
                check("data_ack", ack, exp_ack);
                if (exp_ack) model_rx = dat[k];
            end else begin
                rbyte(k == n - 1, dat[k + 1], got);
                check("rd_data", got, exp_ack ? dat[k] : 8'hFF);
            end
        end
        if (rw) begin
            check("sda_rel_nack", sda_w, 1'b1);
            check("busy_nack", busy, 1'b0);
        end
        stop_c;
        check("busy_stop", busy, 1'b0);
        check("valid_cnt", n_valid - v0, (exp_ack && !rw) ? n : 0);
        check("load_cnt", n_load - l0, (exp_ack && rw) ? n : 0);
        check("rx_data", rx_data, model_rx);
        if (!exp_ack) check("no_drive", n_low - w0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic ack;
        logic r;
        logic [7:0] got;
        int v0;
        #50 rstn = 1'b1;
        #50;
        check("rst_rx", rx_data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_load", tx_load, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sda", sda_w, 1'b1);

        dat[0] = 8'h3C;
        run_xfer(7'h50, 1'b0, 1);

        dat[0] = 8'h96; dat[1] = 8'h5A; dat[2] = 8'h00;
        run_xfer(7'h50, 1'b1, 2);

        dat[0] = 8'h11;
        run_xfer(7'h51, 1'b0, 1);

        dat[0] = 8'hAA;
        run_xfer(7'h00, 1'b0, 1);

        v0 = n_valid;
        start_c;
        wbyte(8'hA0, ack);
        check("sr_ack1", ack, 1'b1);
        wbyte(8'h07, ack);
        check("sr_dack", ack, 1'b1);
        tx_data = 8'hC3;
        start_c;
        wbyte(8'hA1, ack);
        check("sr_ack2", ack, 1'b1);
        rbyte(1'b1, 8'h00, got);
        check("sr_rd", got, 8'hC3);
        stop_c;
        model_rx = 8'h07;
        check("sr_rx", rx_data, 8'h07);
        check("sr_valid", n_valid - v0, 1);

        start_c;
        bitx(1'b1, r); bitx(1'b0, r); bitx(1'b1, r); bitx(1'b0, r);
        m_low = 1'b0;
        rstn = 1'b0;
        #1;
        check("mid_rst_sda", sda_w, 1'b1);
        check("mid_rst_rx", rx_data, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", valid, 1'b0);
        check("mid_rst_load", tx_load, 1'b0);
        model_rx = 8'h00;
        #30 rstn = 1'b1;
        #40;
        dat[0] = 8'h55;
        run_xfer(7'h50, 1'b0, 1);

        for (int t = 0; t < 12; t++) begin
            logic [6:0] a;
            logic rw;
            int n;
            a = $urandom_range(0, 1) ? SLV : 7'($urandom_range(0, 127));
            rw = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            for (int k = 0; k < 5; k++) dat[k] = 8'($urandom);
            run_xfer(a, rw, n);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
